// File: rtl/load_store_unit_if.sv
// Memory bus between the load/store unit (master) and data memory (slave).
// Request is held until ack; read data is valid in the ack cycle.
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output mem_be,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  mem_be,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle load/store engine: register operands in, req/ack bus out,
// load results back on the register file write port.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_load,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [31:0]       base_addr,
    input  logic [31:0]       offset,
    input  logic [31:0]       store_data,
    input  logic [3:0]        dest_reg,
    output logic              busy,
    output logic              done,
    output logic              misaligned,
    output logic              timeout,
    load_store_unit_if.master mem,
    output logic              write_en,
    output logic [3:0]        write_dest,
    output logic [31:0]       write_in
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WB,
        FAULT,
        TOUT
    } state_t;

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
    localparam logic [3:0] IMM  = 4'hF;

    state_t      state;
    state_t      state_nx;

    logic [31:0] ea;
    logic        fault;
    logic [3:0]  be_nx;
    logic [31:0] wdata_nx;
    logic        accept;

    logic        ld_q;
    logic [1:0]  size_q;
    logic        sext_q;
    logic [31:0] ea_q;
    logic [3:0]  dest_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [7:0]  cnt_q;
    logic [3:0]  wdest_q;
    logic [31:0] win_q;

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_val;
    logic        req;
    logic        fault_rpt;
    logic        do_write;

    assign ea     = base_addr + offset;
    assign accept = (state == IDLE) && start;

    always_comb begin
        fault    = 1'b0;
        be_nx    = 4'b1111;
        wdata_nx = store_data;
        case (size)
            2'b00: begin
                be_nx    = 4'b0001 << ea[1:0];
                wdata_nx = {4{store_data[7:0]}};
            end
            2'b01: begin
                fault    = ea[0];
                be_nx    = ea[1] ? 4'b1100 : 4'b0011;
                wdata_nx = {2{store_data[15:0]}};
            end
            default: begin
                fault    = |ea[1:0];
            end
        endcase
    end

    always_comb begin
        byte_v = mem.mem_rdata[7:0];
        case (ea_q[1:0])
            2'd1:    byte_v = mem.mem_rdata[15:8];
            2'd2:    byte_v = mem.mem_rdata[23:16];
            2'd3:    byte_v = mem.mem_rdata[31:24];
            default: byte_v = mem.mem_rdata[7:0];
        endcase
        half_v = ea_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
        case (size_q)
            2'b00:   load_val = {{24{sext_q & byte_v[7]}}, byte_v};
            2'b01:   load_val = {{16{sext_q & half_v[15]}}, half_v};
            default: load_val = mem.mem_rdata;
        endcase
    end

    // A fault is reported one cycle late so it lines up with a zero-wait access.
    assign fault_rpt = (state == FAULT) && (cnt_q != 8'd0);
    assign req       = (state == REQ);
    assign do_write  = ld_q && (dest_q != IMM);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (start) state_nx = fault ? FAULT : REQ;
            REQ: begin
                if (mem.mem_ack)        state_nx = WB;
                else if (cnt_q == LAST) state_nx = TOUT;
            end
            WB:    state_nx = IDLE;
            FAULT: if (cnt_q != 8'd0) state_nx = IDLE;
            TOUT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_q    <= 1'b0;
            size_q  <= 2'b00;
            sext_q  <= 1'b0;
            ea_q    <= 32'd0;
            dest_q  <= 4'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            cnt_q   <= 8'd0;
        end else if (accept) begin
            ld_q    <= is_load;
            size_q  <= size;
            sext_q  <= sign_ext;
            ea_q    <= ea;
            dest_q  <= dest_reg;
            wdata_q <= wdata_nx;
            be_q    <= be_nx;
            cnt_q   <= 8'd0;
        end else if ((req && !mem.mem_ack) || state == FAULT) begin
            cnt_q   <= cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdest_q <= 4'd0;
            win_q   <= 32'd0;
        end else if (req && mem.mem_ack && do_write) begin
            wdest_q <= dest_q;
            win_q   <= load_val;
        end
    end

    assign busy          = (state != IDLE);
    assign done          = (state == WB) || (state == TOUT) || fault_rpt;
    assign misaligned    = fault_rpt;
    assign timeout       = (state == TOUT);
    assign write_en      = (state == WB) && do_write;
    assign write_dest    = wdest_q;
    assign write_in      = win_q;

    assign mem.mem_req   = req;
    assign mem.mem_we    = req && !ld_q;
    assign mem.mem_addr  = req ? {ea_q[31:2], 2'b00} : 32'd0;
    assign mem.mem_wdata = req ? wdata_q : 32'd0;
    assign mem.mem_be    = req ? be_q : 4'd0;

endmodule
